seq_divider_32by16: RTL

//  Sequential radix-2 restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient + N-bit remainder.

---
 rtl/divider_pkg.sv | 16 +
 rtl/seq_divider_32by16_div_step.sv | 29 ++
 rtl/seq_divider_32by16.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential 2N/N restoring divider.
package divider_pkg;

  // Default divisor / quotient / remainder width; the dividend is twice this.
  localparam int unsigned DIV_N  = 16;
  // Width of the iteration counter for the default width.
  localparam int unsigned DIV_CW = $clog2(DIV_N);

  // Controller state encoding (kept as plain 2-bit constants for legacy tools).
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t RUN  = 2'd2;
  localparam state_t DONE = 2'd3;

endpackage

// File: rtl/seq_divider_32by16_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, try to
// subtract the divisor, keep the difference when no borrow occurs.
module div_step
  import divider_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic [N:0]   i_rem,
  input  logic         i_bit,
  input  logic [N-1:0] i_divisor,
  output logic [N:0]   o_rem,
  output logic         o_qbit
);

  logic [N+1:0] w_trial;
  logic [N+1:0] w_diff;
  logic         w_borrow;

  // Trial subtraction; the running remainder's top bit is always 0 between
  // iterations, so the MSB of the (N+2)-bit difference is the borrow-out.
  always_comb begin
    w_trial  = {i_rem, i_bit};
    w_diff   = w_trial - {2'b00, i_divisor};
    w_borrow = w_diff[N+1];
    o_qbit   = ~w_borrow;
    o_rem    = w_borrow ? w_trial[N:0] : w_diff[N:0];
  end

endmodule

// File: rtl/seq_divider_32by16.sv
// Sequential radix-2 restoring divider, 2N-bit dividend by N-bit divisor,
// one quotient bit per clock with a start/busy/done handshake.
module seq_divider_32by16
  import divider_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int unsigned    CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_err_dbz;
  logic          r_err_ovf;

  logic [N:0]    r_rem;
  logic [N-1:0]  r_dvd;
  logic [N-1:0]  r_dvs;
  logic [N-1:0]  r_q;

  logic [N-1:0]  r_quot;
  logic [N-1:0]  r_remo;
  logic          r_dbz;
  logic          r_ovf;

  logic          w_accept;
  logic [N:0]    w_rem_nxt;
  logic          w_qbit;

  // The done pulse is registered one edge after the DONE state, so the
  // controller is already in IDLE while done is high; refusing start while
  // done is up keeps the "start during done is ignored" behaviour.
  assign w_accept = (r_state == IDLE) && start && !r_done;

  div_step #(.N(N)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[N-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_nxt),
    .o_qbit    (w_qbit)
  );

  // Controller: state sequencing, iteration count, busy/done and error decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err_dbz <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        LOAD: begin
          if (r_dvs == '0) begin
            r_err_dbz <= 1'b1;
            r_err_ovf <= 1'b0;
            r_state   <= DONE;
          end else if (r_rem >= {1'b0, r_dvs}) begin
            r_err_dbz <= 1'b0;
            r_err_ovf <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_err_dbz <= 1'b0;
            r_err_ovf <= 1'b0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Datapath: operand capture on accept, then shift/subtract once per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_dvd <= '0;
      r_dvs <= '0;
      r_q   <= '0;
    end else if (w_accept) begin
      r_rem <= {1'b0, dividend[2*N-1:N]};
      r_dvd <= dividend[N-1:0];
      r_dvs <= divisor;
      r_q   <= '0;
    end else if (r_state == RUN) begin
      r_rem <= w_rem_nxt;
      r_dvd <= {r_dvd[N-2:0], 1'b0};
      r_q   <= {r_q[N-2:0], w_qbit};
    end
  end

  // Result registers: updated only on the DONE cycle and held until the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quot <= '0;
      r_remo <= '0;
      r_dbz  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (r_state == DONE) begin
      if (r_err_dbz) begin
        r_quot <= '1;
        r_remo <= r_dvd;
        r_dbz  <= 1'b1;
        r_ovf  <= 1'b0;
      end else if (r_err_ovf) begin
        r_quot <= '1;
        r_remo <= '0;
        r_dbz  <= 1'b0;
        r_ovf  <= 1'b1;
      end else begin
        r_quot <= r_q;
        r_remo <= r_rem[N-1:0];
        r_dbz  <= 1'b0;
        r_ovf  <= 1'b0;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule
